// File: rtl/sticker_sprite_anim_if.sv
// Pixel-path, control and bitmap-load signals of the sticker sprite renderer.
// master: the video/compositor side that drives scan coordinates and commands.
// slave : the sticker_sprite_anim block.
interface sticker_sprite_anim_if #(
   parameter int COORD_W     = 11,
   parameter int SPRITE_LOG2 = 4
);
   logic                       frame_start;
   logic                       pix_valid;
   logic [COORD_W-1:0]         x;
   logic [COORD_W-1:0]         y;
   logic [COORD_W-1:0]         pos_x;
   logic [COORD_W-1:0]         pos_y;
   logic                       trigger;
   logic                       dismiss;
   logic                       wr_en;
   logic [2*SPRITE_LOG2-1:0]   wr_addr;
   logic [1:0]                 wr_data;
   logic                       rgb_valid;
   logic [2:0][7:0]            rgb;        // rgb[0] = R, rgb[1] = G, rgb[2] = B
   logic                       busy;
   logic                       shown;

   modport master (
      output frame_start, pix_valid, x, y, pos_x, pos_y,
      output trigger, dismiss, wr_en, wr_addr, wr_data,
      input  rgb_valid, rgb, busy, shown
   );

   modport slave (
      input  frame_start, pix_valid, x, y, pos_x, pos_y,
      input  trigger, dismiss, wr_en, wr_addr, wr_data,
      output rgb_valid, rgb, busy, shown
   );
endinterface

// File: rtl/sticker_sprite_anim.sv
// Pipelined paletted sprite renderer with power-of-two scaling and a
// frame-synchronous grow/show/shrink animation. Two-clock latency from the
// scan coordinate to the RGB output; transparent pixels come out as (0,0,0).
// Optional macro STICKER_BLINK_EN: blink the sticker while in SHOW with a
// half-period of BLINK_FRAMES frames.
module sticker_sprite_anim #(
   parameter int COORD_W      = 11,
   parameter int SPRITE_LOG2  = 4,
   parameter int SCALE_MAX    = 2,
   parameter int ANIM_FRAMES  = 2,
   parameter int BLINK_FRAMES = 8
) (
   input logic                  clk,
   input logic                  rst,
   sticker_sprite_anim_if.slave bus
);
   localparam int TEX     = 1 << SPRITE_LOG2;
   localparam int DEPTH   = TEX * TEX;
   localparam int AW      = 2 * SPRITE_LOG2;
   localparam int DW      = COORD_W + 2;
   localparam int SCALE_W = (SCALE_MAX < 1) ? 1 : $clog2(SCALE_MAX + 1);
   localparam int CNT_W   = (ANIM_FRAMES < 2) ? 1 : $clog2(ANIM_FRAMES);

   typedef enum logic [1:0] {HIDDEN, GROW, SHOW, SHRINK} state_t;

   state_t               state;
   logic [SCALE_W-1:0]   scale;
   logic [CNT_W-1:0]     cnt;
   logic                 at_step;
   logic                 grow_top;

   // Shadow copy of everything that affects the picture, frozen per frame.
   logic                 s_vis;
   logic [SCALE_W-1:0]   s_scale;
   logic [COORD_W-1:0]   s_px;
   logic [COORD_W-1:0]   s_py;
   logic                 show_vis;

   logic [DW-1:0]        half, side, dx, dy, dx_s, dy_s;
   logic                 in_x, in_y;
   logic                 s1_valid, s1_hit;
   logic [AW-1:0]        s1_addr;
   logic [1:0]           mem [DEPTH];

   function automatic logic [2:0][7:0] palette(input logic [1:0] idx);
      case (idx)
         2'd1:    return {8'd1,   8'd1,   8'd1};
         2'd2:    return {8'd1,   8'd1,   8'd255};
         2'd3:    return {8'd255, 8'd255, 8'd255};
         default: return '0;
      endcase
   endfunction

   assign at_step  = (cnt == CNT_W'(ANIM_FRAMES - 1));
   assign grow_top = (int'(scale) + 1 >= SCALE_MAX);

   // Animation FSM; busy/shown are registered copies of the state.
   // NOTE: every clocked block uses non-blocking assignments only, so all
   // registers see pre-edge values of each other regardless of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HIDDEN;
         scale <= '0;
         cnt   <= '0;
         busy_q_clear();
      end else begin
         bus.busy  <= (state == GROW) || (state == SHRINK);
         bus.shown <= (state != HIDDEN);
         case (state)
            HIDDEN: begin
               if (bus.trigger && !bus.dismiss) begin
                  state <= GROW;
                  scale <= '0;
                  cnt   <= '0;
               end
            end
            GROW: begin
               if (bus.dismiss) begin
                  state <= SHRINK;
                  cnt   <= '0;
               end else if (bus.frame_start) begin
                  if (at_step) begin
                     cnt <= '0;
                     if (grow_top) begin
                        scale <= SCALE_W'(SCALE_MAX);
                        state <= SHOW;
                     end else begin
                        scale <= scale + SCALE_W'(1);
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            SHOW: begin
               if (bus.dismiss) begin
                  state <= SHRINK;
                  cnt   <= '0;
               end
            end
            SHRINK: begin
               if (bus.trigger && !bus.dismiss) begin
                  state <= GROW;
                  cnt   <= '0;
               end else if (bus.frame_start) begin
                  if (at_step) begin
                     cnt <= '0;
                     if (scale == '0) state <= HIDDEN;
                     else             scale <= scale - SCALE_W'(1);
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= HIDDEN;
         endcase
      end
   end

   // Clears the registered status flags on reset.
   task automatic busy_q_clear();
      bus.busy  <= 1'b0;
      bus.shown <= 1'b0;
   endtask

`ifdef STICKER_BLINK_EN
   localparam int BLINK_W = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES);
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_off;

   // Blink phase counter: runs only in SHOW, starts in the visible phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (state != SHOW) begin
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else if (bus.frame_start) begin
         if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            blink_off <= !blink_off;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end
   end

   assign show_vis = !((state == SHOW) && blink_off);
`else
   assign show_vis = 1'b1;
`endif

   // Shadow registers: latch the display state at the frame boundary so the
   // picture never changes mid-frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_vis   <= 1'b0;
         s_scale <= '0;
         s_px    <= '0;
         s_py    <= '0;
      end else if (bus.frame_start) begin
         s_vis   <= (state != HIDDEN) && show_vis;
         s_scale <= scale;
         s_px    <= bus.pos_x;
         s_py    <= bus.pos_y;
      end
   end

   // Offset of the scan point from the sprite's top-left corner; wide enough
   // that a negative offset near the screen edge never wraps into the sprite.
   // NOTE: each signal is assigned unconditionally here, so no latch forms.
   always_comb begin
      half = DW'(1) << (SPRITE_LOG2 - 1 + int'(s_scale));
      side = half << 1;
      dx   = DW'(bus.x) - DW'(s_px) + half;
      dy   = DW'(bus.y) - DW'(s_py) + half;
      dx_s = dx >> s_scale;
      dy_s = dy >> s_scale;
      in_x = !dx[DW-1] && (dx < side);
      in_y = !dy[DW-1] && (dy < side);
   end

   // Stage 1: hit test and texel address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_hit   <= 1'b0;
         s1_addr  <= '0;
      end else begin
         s1_valid <= bus.pix_valid;
         s1_hit   <= s_vis && in_x && in_y;
         s1_addr  <= {dy_s[SPRITE_LOG2-1:0], dx_s[SPRITE_LOG2-1:0]};
      end
   end

   // Bitmap write port.
   // NOTE: the bitmap is deliberately not reset; its contents survive rst.
   always_ff @(posedge clk) begin
      if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
   end

   // Stage 2: bitmap read (old data on a same-address write) and palette.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rgb_valid <= 1'b0;
         bus.rgb       <= '0;
      end else begin
         bus.rgb_valid <= s1_valid;
         bus.rgb       <= s1_hit ? palette(mem[s1_addr]) : '0;
      end
   end
endmodule
